reservation_station: RTL
========================

Name: reservation_station

Overview:
- Consumer end of the issue-to-RS interface: accepts non-memory ops from the issue stage and holds them until both operands are ready.
- Captures operand values from the ALU and LSB common data buses (CDB) and dispatches one ready op per cycle to the ALU as a registered output.
- Sits between issue, the ALU and the ROB flush network.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- ROB_LOG, 4, ROB tag width.
- OP_LOG, 6, opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- rdy  in  1  global enable; when 0 all state and outputs hold.
- clear  in  1  ROB flush (mispredict): discard all entries.
- rs_full  out  1  no free entry (combinational from entry busy bits).
- issue_enable  in  1  new op valid this cycle.
- issue_op  in  OP_LOG  opcode.
- issue_Vj, issue_Vk  in  32  operand values.
- issue_Rj, issue_Rk  in  1  operand ready flags.
- issue_Qj, issue_Qk  in  ROB_LOG  producer tags when not ready.
- issue_Imm  in  32  immediate.
- issue_CurPc  in  32  instruction pc.
- issue_RobId  in  ROB_LOG  destination ROB tag.
- alu_cdb_valid  in  1  ALU result broadcast.
- alu_cdb_RobId  in  ROB_LOG  ALU result tag.
- alu_cdb_value  in  32  ALU result value.
- lsb_cdb_valid  in  1  LSB result broadcast.
- lsb_cdb_RobId  in  ROB_LOG  LSB result tag.
- lsb_cdb_value  in  32  LSB result value.
- alu_enable  out  1  dispatch valid (one-cycle pulse per op).
- alu_op  out  OP_LOG  dispatched opcode.
- alu_Vj, alu_Vk, alu_Imm, alu_CurPc  out  32  dispatched operands.
- alu_RobId  out  ROB_LOG  dispatched tag.

Behaviour:
- Reset (rst=0, async): all busy bits 0; alu_enable 0; all alu_* data outputs 0; rs_full 0.
- rdy=0: no state change and no output change. Inputs are ignored, including clear and issue_enable.
- Each entry holds busy, op, Vj, Rj, Qj, Vk, Rk, Qk, Imm, CurPc and RobId.
- Allocation: on a clock edge with issue_enable=1, the op is written into the lowest-index free entry and its busy bit is set.
  - issue_enable while rs_full=1 is a protocol violation; the op is dropped and state is unchanged.
- Wakeup: every edge, each busy entry whose operand has R=0 and Q equal to a valid CDB tag captures that CDB value and sets R=1.
  - ALU and LSB CDBs are checked independently. The two tags never match the same Q.
- Issue-cycle forwarding: the incoming op is checked against both CDBs in the same cycle. On a match, it is written with V=CDB value and R=1, so a broadcast is never missed.
- Selection: combinational over entries that are busy with Rj=1 and Rk=1 as stored at the start of the cycle. The lowest index wins.
  - On the edge, the winner's fields go to the alu_* registers, alu_enable=1, and the winner's busy bit clears.
  - If there is no winner, alu_enable=0 and the data outputs hold.
- Latency:
  - An op issued with both operands ready at edge N dispatches at edge N+1 (alu_enable high during cycle N+1..N+2).
  - An op woken by a CDB at edge N dispatches at edge N+1 at the earliest.
- Simultaneous allocation and dispatch in one edge is allowed.
  - The freed slot is not reusable until the next edge.
  - rs_full is computed from current busy bits only.
- clear=1 (rdy=1): on that edge all busy bits clear, alu_enable becomes 0 and issue_enable is ignored. Clear has priority over issue, wakeup and dispatch.
- Reset asserted mid-operation behaves exactly as at power-up.
- Throughput: one issue and one dispatch per cycle.

Test Plan:
- Ready op: issue op=ADD, Vj=5, Vk=7, Rj=Rk=1, RobId=3 at edge 0 → edge 1: alu_enable=1, alu_Vj=5, alu_Vk=7, alu_RobId=3; edge 2: alu_enable=0.
- Wakeup: issue RobId=2, Rj=0, Qj=6, Rk=1 → no dispatch. ALU CDB (tag 6, value 0xDEAD) at edge 4 → edge 5: alu_Vj=0xDEAD, alu_RobId=2.
- Issue-cycle forwarding: issue with Qk=9, Rk=0 in the same cycle as LSB CDB tag 9, value 0x1234 → next edge alu_Vk=0x1234. The op must not hang.
- Fill/full: issue 16 ops, all Rj=0, Qj=1 → rs_full=1 after the 16th. Broadcast tag 1 → dispatches in index order 0..15 on consecutive edges, and rs_full drops after the first dispatch.
- Flush: 5 waiting entries plus a dispatch pending, assert clear → next edge alu_enable=0 and rs_full=0. A later CDB with the old tag produces no dispatch.
- Stall/reset: rdy=0 with ready entries → alu_enable frozen for 3 cycles. Async rst low between edges → alu_enable=0 immediately and all entries free.

Source files
------------

// File: rtl/reservation_station.sv
// Reservation station for non-memory ops. Holds issued ops until both operands are ready,
// captures operands from the ALU/LSB CDBs and dispatches the lowest ready entry each cycle.
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_LOG = 4,
  parameter int OP_LOG  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  output logic               rs_full,
  input  logic               issue_enable,
  input  logic [OP_LOG-1:0]  issue_op,
  input  logic [31:0]        issue_Vj,
  input  logic [31:0]        issue_Vk,
  input  logic               issue_Rj,
  input  logic               issue_Rk,
  input  logic [ROB_LOG-1:0] issue_Qj,
  input  logic [ROB_LOG-1:0] issue_Qk,
  input  logic [31:0]        issue_Imm,
  input  logic [31:0]        issue_CurPc,
  input  logic [ROB_LOG-1:0] issue_RobId,
  input  logic               alu_cdb_valid,
  input  logic [ROB_LOG-1:0] alu_cdb_RobId,
  input  logic [31:0]        alu_cdb_value,
  input  logic               lsb_cdb_valid,
  input  logic [ROB_LOG-1:0] lsb_cdb_RobId,
  input  logic [31:0]        lsb_cdb_value,
  output logic               alu_enable,
  output logic [OP_LOG-1:0]  alu_op,
  output logic [31:0]        alu_Vj,
  output logic [31:0]        alu_Vk,
  output logic [31:0]        alu_Imm,
  output logic [31:0]        alu_CurPc,
  output logic [ROB_LOG-1:0] alu_RobId
);

  localparam int IDX = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy, rj, rk;
  logic [OP_LOG-1:0]  op  [RS_SIZE];
  logic [31:0]        vj  [RS_SIZE];
  logic [31:0]        vk  [RS_SIZE];
  logic [31:0]        imm [RS_SIZE];
  logic [31:0]        pc  [RS_SIZE];
  logic [ROB_LOG-1:0] qj  [RS_SIZE];
  logic [ROB_LOG-1:0] qk  [RS_SIZE];
  logic [ROB_LOG-1:0] rob [RS_SIZE];

  logic [IDX-1:0] free_idx, sel_idx;
  logic           sel_found;
  logic [31:0]    in_vj, in_vk;
  logic           in_rj, in_rk;

  assign rs_full = &busy;

  // Descending scan so the last hit, i.e. the lowest index, wins.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX'(i);
      if (busy[i] && rj[i] && rk[i]) begin
        sel_idx   = IDX'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Forward a same-cycle broadcast into the op being issued.
  always_comb begin
    in_vj = issue_Vj;
    in_rj = issue_Rj;
    in_vk = issue_Vk;
    in_rk = issue_Rk;
    if (!issue_Rj && alu_cdb_valid && issue_Qj == alu_cdb_RobId) begin
      in_vj = alu_cdb_value;
      in_rj = 1'b1;
    end else if (!issue_Rj && lsb_cdb_valid && issue_Qj == lsb_cdb_RobId) begin
      in_vj = lsb_cdb_value;
      in_rj = 1'b1;
    end
    if (!issue_Rk && alu_cdb_valid && issue_Qk == alu_cdb_RobId) begin
      in_vk = alu_cdb_value;
      in_rk = 1'b1;
    end else if (!issue_Rk && lsb_cdb_valid && issue_Qk == lsb_cdb_RobId) begin
      in_vk = lsb_cdb_value;
      in_rk = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      rj         <= '0;
      rk         <= '0;
      alu_enable <= 1'b0;
      alu_op     <= '0;
      alu_Vj     <= '0;
      alu_Vk     <= '0;
      alu_Imm    <= '0;
      alu_CurPc  <= '0;
      alu_RobId  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op[i]  <= '0;
        vj[i]  <= '0;
        vk[i]  <= '0;
        imm[i] <= '0;
        pc[i]  <= '0;
        qj[i]  <= '0;
        qk[i]  <= '0;
        rob[i] <= '0;
      end
    end else if (rdy) begin
      if (clear) begin
        busy       <= '0;
        alu_enable <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            if (!rj[i] && alu_cdb_valid && qj[i] == alu_cdb_RobId) begin
              vj[i] <= alu_cdb_value;
              rj[i] <= 1'b1;
            end else if (!rj[i] && lsb_cdb_valid && qj[i] == lsb_cdb_RobId) begin
              vj[i] <= lsb_cdb_value;
              rj[i] <= 1'b1;
            end
            if (!rk[i] && alu_cdb_valid && qk[i] == alu_cdb_RobId) begin
              vk[i] <= alu_cdb_value;
              rk[i] <= 1'b1;
            end else if (!rk[i] && lsb_cdb_valid && qk[i] == lsb_cdb_RobId) begin
              vk[i] <= lsb_cdb_value;
              rk[i] <= 1'b1;
            end
          end
        end

        if (sel_found) begin
          busy[sel_idx] <= 1'b0;
          alu_enable    <= 1'b1;
          alu_op        <= op[sel_idx];
          alu_Vj        <= vj[sel_idx];
          alu_Vk        <= vk[sel_idx];
          alu_Imm       <= imm[sel_idx];
          alu_CurPc     <= pc[sel_idx];
          alu_RobId     <= rob[sel_idx];
        end else begin
          alu_enable <= 1'b0;
        end

        // free_idx is never busy, so it cannot collide with wakeup or dispatch writes.
        if (issue_enable && !rs_full) begin
          busy[free_idx] <= 1'b1;
          op[free_idx]   <= issue_op;
          vj[free_idx]   <= in_vj;
          rj[free_idx]   <= in_rj;
          qj[free_idx]   <= issue_Qj;
          vk[free_idx]   <= in_vk;
          rk[free_idx]   <= in_rk;
          qk[free_idx]   <= issue_Qk;
          imm[free_idx]  <= issue_Imm;
          pc[free_idx]   <= issue_CurPc;
          rob[free_idx]  <= issue_RobId;
        end
      end
    end
  end

endmodule
